downsampler: RTL and testbench
==============================

# downsampler

Rate-reduction stage of the CIC decimator. It sits between the last integrator and the first comb. It keeps one of every `rate` input words and discards the rest. Kept words pass through a 2-entry output buffer, which absorbs backpressure from the comb chain. An overrun that drops a word sets a sticky flag.

## Interface
Parameters:
- `WordLengthBits`, 29: width of the 2's-complement data word, same as the integrator and comb stages.
- `MaxRate`, 64: largest supported decimation rate, ≥ 2.
- `RateBits`, `$clog2(MaxRate+1)`: width of the `rate` port. Derived; do not override.

Ports (clock and reset first):
- `clk`, in, 1: clock. This is the block's single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `in`, in, `WordLengthBits` (signed): integrator output word.
- `in_valid`, in, 1: `in` carries a new word this cycle. No upstream stall exists; every valid word is consumed.
- `rate`, in, `RateBits`: requested decimation rate.
- `clear_overrun`, in, 1: clears `overrun`.
- `out`, out, `WordLengthBits` (signed): head of the output buffer.
- `out_valid`, out, 1: the output buffer is non-empty.
- `out_ready`, in, 1: downstream accepts `out` this cycle.
- `overrun`, out, 1: sticky flag; a kept word was dropped because the buffer was full.

## Operation
Rate latch:
- `rate_q` is loaded on the first cycle after `rst` deasserts, and again on every wrap of the phase counter.
- Effective rate: 0 or 1 maps to 1; values above `MaxRate` clamp to `MaxRate`.
- A change to `rate` mid-group takes effect only at the next group boundary. No partial or short groups are produced.

Phase counter:
- `phase` counts from 0 to `rate_q`-1 and advances only when `in_valid` is high.
- When `in_valid` is high and `phase == rate_q-1`, the word is kept ("push"). `phase` then wraps to 0 and `rate_q` reloads.
- After reset the first kept word is input number `rate_q` (1-based). With rate 1, every word is kept.

Output buffer (2 entries, FIFO order):
- Pop occurs when `out_valid && out_ready`.
- Push and pop in the same cycle are always legal, including when the buffer is full: the pop frees a slot.
- Push when full with no pop: the new word is dropped, the buffer is unchanged, and `overrun` is set to 1.
- `out` and `out_valid` hold stable while `out_valid && !out_ready`.

Overrun flag:
- Cleared by `rst` or by `clear_overrun`.
- If a set and `clear_overrun` occur in the same cycle, the set wins.

No arithmetic is performed; words pass bit-exact.

## Timing
- Reset values: `out`=0, `out_valid`=0, `overrun`=0, `phase`=0, buffer empty, `rate_q`=1 until the post-reset load.
- Latency: a word kept at cycle n appears on `out` with `out_valid`=1 at n+1, provided the buffer was empty or popped in that cycle.
- Throughput: one kept word per cycle at rate 1 when `out_ready` is held high.
- All outputs are registered; there is no combinational path from `out_ready` to `out_valid`.
- `rst` asserted mid-group discards the partial group and all buffered words. `overrun` also clears.

## Structure
- Shared package `cic_pkg` holds:
  - the default `WordLengthBits` constant, shared by integrator, downsampler and comb;
  - the `rate` width helper function.
- The buffer is the sub-module `stream_fifo2`: 2-entry FIFO with push, pop, full, empty, and head data. This module then contains only the rate latch, phase counter, and overrun logic.

## Test plan
1. Reset, then rate=4, `in_valid` constant, in=1,2,3,…, `out_ready`=1. Required: out=4,8,12,…, one `out_valid` pulse per 4 inputs, each one cycle after its input.
2. Rate=1 with `out_ready`=1. Required: every word is passed at 1-cycle latency. Then rate=0: identical behaviour.
3. Rate changed from 4 to 2 while `phase`=1. Required: the current group completes as 4 words, then groups of 2 follow. Rate=200 with MaxRate=64: groups of 64.
4. Rate=1 with `out_ready`=0 for 3 inputs 10,20,30. Required: out=10 held with `out_valid`=1, 30 dropped, `overrun`=1. Raising `out_ready` delivers 10 then 20 on successive cycles.
5. Buffer full with push and pop in the same cycle. Required: no drop and `overrun` stays 0. Then `clear_overrun` coinciding with a new drop. Required: `overrun` remains 1.
6. `rst` pulsed mid-group with 2 words buffered. Required: `out_valid`=0 next cycle, the phase restarts, and the first output after reset is the `rate`-th post-reset input.

Source files
------------

// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants and helpers for the CIC decimator stages
package cic_pkg;

    // Default data word width shared by integrator, downsampler and comb stages.
    localparam int WORD_LENGTH_BITS = 29;

    // Width of a port able to carry any rate value in 0..max_rate.
    function automatic int rate_width(input int max_rate);
        return $clog2(max_rate + 1);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry registered FIFO with head-of-queue data
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write request and word; ignored when full without a pop
//   pop               remove head word; ignored when empty
//   full, empty       registered occupancy flags
//   head_data         registered oldest word (stale when empty)
module stream_fifo2 #(
    parameter int Width = 29
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head_data
);

    logic [Width-1:0] head_q;
    logic [Width-1:0] tail_q;
    logic             empty_q;
    logic             full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else if (empty_q) begin
            if (push) begin
                head_q  <= push_data;
                empty_q <= 1'b0;
            end
        end else if (!full_q) begin
            // One entry held: a simultaneous push and pop replaces the head.
            if (push && pop) begin
                head_q <= push_data;
            end else if (push) begin
                tail_q <= push_data;
                full_q <= 1'b1;
            end else if (pop) begin
                empty_q <= 1'b1;
            end
        end else begin
            // Full: a pop frees the head slot, so a push in the same cycle fits.
            if (pop) begin
                head_q <= tail_q;
                if (push) begin
                    tail_q <= push_data;
                end else begin
                    full_q <= 1'b0;
                end
            end
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign head_data = head_q;

endmodule

// File: rtl/downsampler.sv
// rtl/downsampler.sv - CIC rate reduction: keep one word per group, buffer for the comb chain
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in, in_valid      integrator word stream, never stalled
//   rate              requested decimation rate (0/1 -> 1, above MaxRate -> MaxRate)
//   clear_overrun     clears the sticky overrun flag (a same-cycle drop wins)
//   out, out_valid    head of the 2-entry output buffer
//   out_ready         downstream accepts out this cycle
//   overrun           sticky: a kept word was dropped on a full buffer
module downsampler
    import cic_pkg::*;
#(
    parameter int WordLengthBits = WORD_LENGTH_BITS,
    parameter int MaxRate        = 64,
    parameter int RateBits       = rate_width(MaxRate)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic signed [WordLengthBits-1:0] in,
    input  logic                             in_valid,
    input  logic        [RateBits-1:0]       rate,
    input  logic                             clear_overrun,
    output logic signed [WordLengthBits-1:0] out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overrun
);

    function automatic logic [RateBits-1:0] eff_rate(input logic [RateBits-1:0] r);
        if (r <= RateBits'(1)) begin
            return RateBits'(1);
        end else if (r > RateBits'(MaxRate)) begin
            return RateBits'(MaxRate);
        end
        return r;
    endfunction

    logic [RateBits-1:0] rate_q;
    logic [RateBits-1:0] phase;
    logic                loaded;
    logic                overrun_q;
    logic [RateBits-1:0] rate_cur;
    logic                push;
    logic                pop;
    logic                drop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WordLengthBits-1:0] head_data;

    // In the load cycle right after reset the latch has not been written yet;
    // use the requested rate directly so the first group already has full length.
    always_comb begin
        rate_cur = loaded ? rate_q : eff_rate(rate);
        push     = in_valid && (phase == rate_cur - RateBits'(1));
        pop      = !fifo_empty && out_ready;
        drop     = push && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rate_q    <= RateBits'(1);
            phase     <= '0;
            loaded    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (!loaded) begin
                loaded <= 1'b1;
                rate_q <= eff_rate(rate);
            end
            if (in_valid) begin
                if (push) begin
                    phase  <= '0;
                    rate_q <= eff_rate(rate);
                end else begin
                    phase <= phase + RateBits'(1);
                end
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    stream_fifo2 #(
        .Width(WordLengthBits)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_data)
    );

    assign out       = head_data;
    assign out_valid = !fifo_empty;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_downsampler.sv
// tb/tb_downsampler.sv - self-checking bench for downsampler
module tb_downsampler;

    localparam int W  = 29;
    localparam int MR = 64;
    localparam int RB = $clog2(MR + 1);

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] in;
    logic                in_valid;
    logic [RB-1:0]       rate;
    logic                clear_overrun;
    logic signed [W-1:0] out;
    logic                out_valid;
    logic                out_ready;
    logic                overrun;

    always #5 clk = ~clk;

    downsampler #(
        .WordLengthBits(W),
        .MaxRate       (MR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in            (in),
        .in_valid      (in_valid),
        .rate          (rate),
        .clear_overrun (clear_overrun),
        .out           (out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overrun       (overrun)
    );

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    typedef struct {
        int r_in;
        int count;
        int base;
        int group;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        exp_t e;
        int   o;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_acc++;
            o = out;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got %0d, expected no output (cycle %0d)", o, cyc);
            end else begin
                e = sb.pop_front();
                chk("out_data", o, e.data);
                if (e.cyc >= 0) chk("out_cycle", cyc, e.cyc);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int r);
        rst           = 1'b1;
        in_valid      = 1'b0;
        in            = '0;
        out_ready     = 1'b0;
        clear_overrun = 1'b0;
        rate          = RB'(r);
        step();
        step();
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
    endtask

    task automatic feed(input int v, input bit keep, input bit timed);
        in       = W'(v);
        in_valid = 1'b1;
        if (keep) sb.push_back('{v, timed ? cyc + 1 : -1});
        step();
    endtask

    task automatic drain(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int start;

        vecs[0] = '{4,   12, 1,    4};
        vecs[1] = '{1,   6,  100,  1};
        vecs[2] = '{0,   6,  200,  1};
        vecs[3] = '{100, 130, 1000, 64};
        vecs[4] = '{2,   8,  -5,   2};
        vecs[5] = '{3,   9,  7,    3};

        do_reset(4);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_overrun", int'(overrun), 0);

        // Streaming groups, driven from the first cycle after reset.
        for (int k = 0; k < 6; k++) begin
            do_reset(vecs[k].r_in);
            start = n_acc;
            for (int i = 0; i < vecs[k].count; i++) begin
                feed(vecs[k].base + i, ((i + 1) % vecs[k].group) == 0, 1'b1);
            end
            drain(3);
            chk("out_count", n_acc - start, vecs[k].count / vecs[k].group);
            chk("overrun_stream", int'(overrun), 0);
        end

        // Rate change mid-group: current group of 4 completes, then groups of 2.
        do_reset(4);
        feed(1, 1'b0, 1'b1);
        rate = RB'(2);
        feed(2, 1'b0, 1'b1);
        feed(3, 1'b0, 1'b1);
        feed(4, 1'b1, 1'b1);
        feed(5, 1'b0, 1'b1);
        feed(6, 1'b1, 1'b1);
        feed(7, 1'b0, 1'b1);
        feed(8, 1'b1, 1'b1);
        drain(3);

        // Backpressure with overrun.
        do_reset(1);
        out_ready = 1'b0;
        feed(10, 1'b1, 1'b0);
        feed(20, 1'b1, 1'b0);
        feed(30, 1'b0, 1'b0);
        chk("bp_overrun", int'(overrun), 1);
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_out", int'(out), 10);
        in_valid = 1'b0;
        step();
        chk("bp_hold", int'(out), 10);
        out_ready = 1'b1;
        step();
        chk("bp_second", int'(out), 20);
        chk("bp_second_valid", int'(out_valid), 1);
        drain(2);
        chk("bp_empty_valid", int'(out_valid), 0);

        // Full buffer with push and pop together, then clear colliding with a drop.
        do_reset(1);
        out_ready = 1'b0;
        feed(1, 1'b1, 1'b0);
        feed(2, 1'b1, 1'b0);
        out_ready = 1'b1;
        feed(3, 1'b1, 1'b0);
        chk("pp_overrun", int'(overrun), 0);
        out_ready     = 1'b0;
        clear_overrun = 1'b1;
        feed(4, 1'b0, 1'b0);
        chk("clr_vs_set", int'(overrun), 1);
        in_valid = 1'b0;
        step();
        chk("clr_alone", int'(overrun), 0);
        clear_overrun = 1'b0;
        drain(3);

        // Reset mid-group with two buffered words.
        do_reset(3);
        out_ready = 1'b0;
        for (int i = 1; i <= 7; i++) feed(i, (i % 3) == 0, 1'b0);
        chk("pre_rst_valid", int'(out_valid), 1);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) feed(100 + i, (i % 3) == 0, 1'b1);
        drain(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
